// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port fixed-priority arbiter and sequencer for the big-endian data memory.
//   Port 0 (CPU MEM stage) has priority. A starvation counter guarantees port 1 (loader/debug)
//   a grant once it has lost STARVE_LIMIT times in a row.
//   Every access takes IDLE (grant) -> SERVE (memory cycle) -> RESP (ack).
// Optional feature: define DMEM_ARB_RANGE_CHECK_EN to reject accesses outside
//   [ADDR_BASE, ADDR_BASE+MEM_BYTES). A rejected access gets pN_err and zero rdata.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pN_req/we/addr/wdata request side (N = 0,1); req is held until pN_ack
//   pN_ack/rdata/err     one-cycle completion pulse, read word (held), out-of-range flag
//   mem_read/mem_write   memory enables, asserted only in SERVE
//   mem_address/mem_data memory address and write word, held outside SERVE
//   mem_result           combinational memory read data
module dmem_arbiter #(
    parameter int ADDR_BASE    = 1024,
    parameter int MEM_BYTES    = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_result
);
    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;
    logic        pick1;
    logic        in_range;
    logic [31:0] rd_word;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    // The last byte of the addressed word must also lie inside the memory.
    assign in_range = ({1'b0, addr_q} >= 33'(ADDR_BASE)) &&
                      ({1'b0, addr_q[31:2], 2'b11} < 33'(ADDR_BASE + MEM_BYTES));
`else
    assign in_range = 1'b1;
`endif
    assign rd_word = in_range ? mem_result : 32'h0;
    // Port 1 wins only when uncontested or once port 0 has used up its tolerated wins.
    assign pick1 = p1_req & (~p0_req | (wait_q == LIMIT));
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wait_d     = wait_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        case (state_q)
            IDLE: if (p0_req | p1_req) begin
                state_d = SERVE;
                gnt_d   = pick1;
                we_d    = pick1 ? p1_we : p0_we;
                addr_d  = pick1 ? p1_addr : p0_addr;
                data_d  = pick1 ? p1_wdata : p0_wdata;
                wait_d  = pick1 ? 4'd0 : (p1_req && wait_q != LIMIT) ? wait_q + 4'd1 : wait_q;
            end
            SERVE: begin
                state_d = RESP;
                if (!we_q && gnt_q) p1_rdata_d = rd_word;
                if (!we_q && !gnt_q) p0_rdata_d = rd_word;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            wait_q     <= 4'd0;
            p0_rdata_q <= 32'h0;
            p1_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wait_q     <= wait_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end
    // The latched address/data feed the memory pins directly: loaded at the grant edge,
    // they are valid through SERVE and simply hold afterwards.
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_read    = (state_q == SERVE) & ~we_q & in_range;
    assign mem_write   = (state_q == SERVE) & we_q & in_range;
    assign p0_ack      = (state_q == RESP) & ~gnt_q;
    assign p1_ack      = (state_q == RESP) & gnt_q;
    assign p0_err      = p0_ack & ~in_range;
    assign p1_err      = p1_ack & ~in_range;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a big-endian memory model.
module tb_dmem_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_data, mem_result;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  mem [256];
    logic [31:0] off;
    logic [7:0]  wi;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_data(mem_data), .mem_result(mem_result)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    always_comb begin
        off = mem_address - 32'd1024;
        wi = {off[7:2], 2'b00};
        mem_result = (mem_address >= 32'd1024 && mem_address < 32'd1280) ?
                     {mem[wi], mem[wi + 8'd1], mem[wi + 8'd2], mem[wi + 8'd3]} : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_write && mem_address >= 32'd1024 && mem_address < 32'd1280) begin
            mem[wi]        <= mem_data[31:24];
            mem[wi + 8'd1] <= mem_data[23:16];
            mem[wi + 8'd2] <= mem_data[15:8];
            mem[wi + 8'd3] <= mem_data[7:0];
        end
    end

    // Drives one access on a port, starting #1 after an edge with the FSM idle; returns
    // the number of edges until ack, plus what was seen on the memory enables.
    task automatic acc(input logic port, input logic we, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic saw_w, output logic saw_r,
                       output logic err, output logic [31:0] rd);
        logic ack;
        if (port) begin p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1; end
        else begin p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1; end
        lat = 0; saw_w = 0; saw_r = 0; ack = 0; err = 0; rd = 0;
        while (!ack && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            saw_w |= mem_write;
            saw_r |= mem_read;
            ack = port ? p1_ack : p0_ack;
            err = port ? p1_err : p0_err;
            rd  = port ? p1_rdata : p0_rdata;
        end
        p0_req = 0; p1_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if ({mem_read, mem_write, p0_ack, p1_ack, p0_err, p1_err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 000000",
                {mem_read, mem_write, p0_ack, p1_ack, p0_err, p1_err});
        end
        n_checks++;
        if ({mem_address, mem_data, p0_rdata, p1_rdata} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h %h want 0",
                mem_address, mem_data, p0_rdata, p1_rdata);
        end
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        int lat; logic sw, sr, e; logic [31:0] rd;
        acc(0, 1, 32'd1024, 32'h00000055, lat, sw, sr, e, rd);
        n_checks++;
        if (lat !== 2 || sw !== 1'b1) begin
            n_fail++; $display("FAIL wr_latency got lat=%0d wr=%b want lat=2 wr=1", lat, sw);
        end
        n_checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h00000055) begin
            n_fail++; $display("FAIL wr_bytes got %h %h %h %h want 00 00 00 55",
                mem[0], mem[1], mem[2], mem[3]);
        end
        acc(0, 0, 32'd1024, 32'h0, lat, sw, sr, e, rd);
        n_checks++;
        if (lat !== 2 || rd !== 32'h00000055 || sr !== 1'b1) begin
            n_fail++; $display("FAIL rd_word got lat=%0d rdata=%h rd=%b want lat=2 rdata=00000055 rd=1",
                lat, rd, sr);
        end
        n_checks++;
        if (p0_rdata !== 32'h00000055) begin
            n_fail++; $display("FAIL rd_hold got %h want 00000055", p0_rdata);
        end
    endtask

    task automatic test_simultaneous;
        int t0, t1; logic clash;
        t0 = -1; t1 = -1; clash = 0;
        p0_we = 0; p0_addr = 32'd1028; p0_req = 1;
        p1_we = 1; p1_addr = 32'd1032; p1_wdata = 32'hDEADBEEF; p1_req = 1;
        for (int c = 1; c <= 20 && t1 < 0; c++) begin
            @(posedge clk); #1;
            if (p0_ack && p1_ack) clash = 1;
            if (p0_ack) begin t0 = c; p0_req = 0; end
            if (p1_ack) begin t1 = c; p1_req = 0; end
        end
        p0_req = 0; p1_req = 0;
        @(posedge clk); #1;
        n_checks++;
        if (t0 !== 2 || t1 !== 5 || clash !== 1'b0) begin
            n_fail++; $display("FAIL sim_order got t0=%0d t1=%0d clash=%b want t0=2 t1=5 clash=0",
                t0, t1, clash);
        end
        n_checks++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sim_p1_write got %h%h%h%h want deadbeef",
                mem[8], mem[9], mem[10], mem[11]);
        end
    endtask

    task automatic test_starvation;
        int n0; logic got;
        n0 = 0; got = 0;
        p0_we = 0; p0_addr = 32'd1028; p0_req = 1;
        p1_we = 0; p1_addr = 32'd1024; p1_req = 1;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clk); #1;
            if (p0_ack) n0++;
            if (p1_ack) got = 1;
        end
        p0_req = 0; p1_req = 0;
        n_checks++;
        if (got !== 1'b1 || n0 !== 4) begin
            n_fail++; $display("FAIL starve_grants got p1_acked=%b p0_wins=%0d want 1 and 4", got, n0);
        end
        n_checks++;
        if (dut.wait_q !== 4'd0 || p1_rdata !== 32'h00000055) begin
            n_fail++; $display("FAIL starve_after got wait=%0d p1_rdata=%h want 0 00000055",
                dut.wait_q, p1_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_range;
        int lat; logic sw, sr, e; logic [31:0] rd;
`ifdef DMEM_ARB_RANGE_CHECK_EN
        acc(1, 0, 32'd2000, 32'h0, lat, sw, sr, e, rd);
        n_checks++;
        if (lat !== 2 || sr !== 1'b0 || e !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL range_rd got lat=%0d rd=%b err=%b rdata=%h want 2 0 1 0",
                lat, sr, e, rd);
        end
        acc(0, 1, 32'd1023, 32'hFFFFFFFF, lat, sw, sr, e, rd);
        n_checks++;
        if (lat !== 2 || sw !== 1'b0 || e !== 1'b1) begin
            n_fail++; $display("FAIL range_wr got lat=%0d wr=%b err=%b want 2 0 1", lat, sw, e);
        end
        acc(0, 1, 32'd1276, 32'hA5A5A5A5, lat, sw, sr, e, rd);
        n_checks++;
        if (sw !== 1'b1 || e !== 1'b0 || {mem[252], mem[253], mem[254], mem[255]} !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL range_top got wr=%b err=%b want 1 0", sw, e);
        end
`else
        acc(1, 0, 32'd2000, 32'h0, lat, sw, sr, e, rd);
        n_checks++;
        if (lat !== 2 || sr !== 1'b1 || e !== 1'b0) begin
            n_fail++; $display("FAIL norange_rd got lat=%0d rd=%b err=%b want 2 1 0", lat, sr, e);
        end
        acc(0, 1, 32'd1276, 32'hA5A5A5A5, lat, sw, sr, e, rd);
        n_checks++;
        if (sw !== 1'b1 || e !== 1'b0 || {mem[252], mem[253], mem[254], mem[255]} !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL norange_top got wr=%b err=%b want 1 0", sw, e);
        end
`endif
    endtask

    task automatic test_reset_mid_serve;
        logic seen_ack;
        seen_ack = 0;
        p0_we = 1; p0_addr = 32'd1036; p0_wdata = 32'h12345678; p0_req = 1;
        @(posedge clk); #1;
        n_checks++;
        if (mem_write !== 1'b1) begin
            n_fail++; $display("FAIL rst_serve_pre got mem_write=%b want 1", mem_write);
        end
        #2 rst = 1;
        #1;
        n_checks++;
        if ({mem_read, mem_write, p0_ack, p1_ack, p0_err, p1_err} !== 6'b0 ||
            {mem_address, mem_data, p0_rdata, p1_rdata} !== 128'h0) begin
            n_fail++; $display("FAIL rst_serve_outs got ctl=%b addr=%h data=%h r0=%h r1=%h want 0",
                {mem_read, mem_write, p0_ack, p1_ack, p0_err, p1_err}, mem_address, mem_data,
                p0_rdata, p1_rdata);
        end
        p0_req = 0;
        @(posedge clk); #1;
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (p0_ack || p1_ack) seen_ack = 1;
        end
        n_checks++;
        if (seen_ack !== 1'b0 || {mem[12], mem[13], mem[14], mem[15]} !== 32'h0) begin
            n_fail++; $display("FAIL rst_serve_drop got ack=%b bytes=%h%h%h%h want 0 00000000",
                seen_ack, mem[12], mem[13], mem[14], mem[15]);
        end
    endtask

    task automatic test_back_to_back;
        int a1, a2;
        a1 = -1; a2 = -1;
        p0_we = 0; p0_addr = 32'd1024; p0_req = 1;
        for (int c = 1; c <= 20 && a2 < 0; c++) begin
            @(posedge clk); #1;
            if (p0_ack && a1 < 0) a1 = c;
            else if (p0_ack) begin a2 = c; p0_req = 0; end
        end
        p0_req = 0;
        @(posedge clk); #1;
        n_checks++;
        if (a1 !== 2 || a2 !== 5 || p0_rdata !== 32'h00000055) begin
            n_fail++; $display("FAIL rearm got a1=%0d a2=%0d rdata=%h want 2 5 00000055", a1, a2, p0_rdata);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_simultaneous;
        test_starvation;
        test_range;
        test_reset_mid_serve;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Two-requester arbiter and sequencer for the byte-addressed, big-endian data memory (base address 1024, 256 bytes, single-cycle write, combinational read).
- Port 0 is the CPU MEM stage; port 1 is the loader/debug port.
- Requests are granted one at a time, each as a single-word access. Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress.
- Address range checking is optional (see Configuration). Sits between the pipeline/loader and the memory's mem_read/mem_write/address/data/mem_result pins.

## Interface

- ADDR_BASE, 1024: byte address of memory byte 0.
- MEM_BYTES, 256: memory size in bytes.
- STARVE_LIMIT, 4: port-0 wins that port 1 tolerates while requesting; range 1-15.

- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pN_req  in  1  request, N = 0,1; held until pN_ack.
- pN_we  in  1  1 = write, 0 = read.
- pN_addr  in  32  byte address; bits [1:0] are ignored by memory word indexing.
- pN_wdata  in  32  write word.
- pN_ack  out  1  one-cycle completion pulse.
- pN_rdata  out  32  read word; valid while pN_ack = 1, then held.
- pN_err  out  1  out-of-range flag; valid with pN_ack.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_address  out  32  memory address.
- mem_data  out  32  memory write data.
- mem_result  in  32  memory read data (combinational).

## Operation

- FSM states: IDLE, SERVE, RESP.
- **IDLE.** Sample requests.
  - If only one pN_req is high, grant that port.
  - If both are high, grant port 1 when wait_cnt == STARVE_LIMIT; otherwise grant port 0.
  - On grant, latch the port id, we, addr and wdata, then go to SERVE.
  - With no request, stay in IDLE.
- **wait_cnt (4-bit).**
  - Increments, saturating at STARVE_LIMIT, on each port-0 grant while p1_req = 1.
  - Clears on each port-1 grant.
- **SERVE (1 cycle).** Drive mem_address and mem_data from the latch.
  - mem_write = latched we. The write commits at the SERVE→RESP edge.
  - mem_read = ~latched we.
  - At the edge, mem_result is captured into the granted port's rdata register on a read. A write leaves rdata unchanged.
  - Go to RESP.
- **RESP (1 cycle).** Assert the granted port's pN_ack = 1. The other port's ack stays 0. Go to IDLE.
- **Outside SERVE.**
  - mem_read = mem_write = 0.
  - mem_address and mem_data hold their last values.
- **Requester rule.** A requester must drop req (or present a new request) in the cycle following ack. A req still high in IDLE is a new request.
- **Request changes.** pN_addr, pN_we and pN_wdata may change after the grant edge, because they are latched.
- **Reset, anytime including mid-SERVE.**
  - State returns to IDLE; wait_cnt = 0.
  - mem_read, mem_write, pN_ack and pN_err = 0.
  - mem_address, mem_data and pN_rdata = 0.
  - The interrupted access is dropped with no ack, and no write occurs after rst rises.

## Timing

- Request high before edge k (FSM in IDLE):
  - edge k: grant;
  - cycle k→k+1: SERVE;
  - edge k+1: write commit / read capture;
  - cycle k+1→k+2: ack high.
- Latency is 2 cycles from the grant edge to ack.
- Throughput is one access per 3 cycles.
- A held lower-priority request sees its grant at the first IDLE after the current RESP.
- Both requests arriving at the same edge: arbitration follows the IDLE rule; the loser stays pending.

## Configuration

- DMEM_ARB_RANGE_CHECK_EN defined:
  - An access is in range when ADDR_BASE ≤ addr and addr − addr[1:0] + 3 < ADDR_BASE + MEM_BYTES.
  - An out-of-range access still passes through SERVE, with mem_read = mem_write = 0.
  - It then gets ack with pN_err = 1 and pN_rdata = 0.
- Undefined:
  - Every address is forwarded unchanged.
  - pN_err is tied to 0.

## Test plan

- **Basic write then read.**
  - rst pulse; p0 writes 0x00000055 to 1024.
  - Required: ack 2 cycles after grant, and memory bytes 0..3 = 00,00,00,55.
  - Then p0 reads 1024: p0_rdata = 0x00000055 with p0_ack.
- **Simultaneous requests.**
  - p0 and p1 both request at the same edge (p0 read 1028, p1 write 0xDEADBEEF to 1032).
  - Required: p0 acked first; p1 acked 3 cycles later; p1_ack never coincides with p0_ack.
- **Starvation.**
  - p0 re-requests continuously with p1_req held with STARVE_LIMIT = 4.
  - Required: p1 is granted after exactly 4 p0 grants, then wait_cnt = 0.
- **Range check (macro defined).**
  - p1 reads 2000.
  - Required: mem_read stays 0, p1_ack = 1, p1_err = 1, p1_rdata = 0.
  - p0 writes 1023: no mem_write pulse, p0_err = 1.
- **Reset mid-SERVE.**
  - Assert rst during the SERVE of a write of 0x12345678 to 1036.
  - Required: all outputs 0 immediately, no ack, and bytes 12..15 still 0.
- **Held request re-arm.**
  - p0 keeps req high after ack.
  - Required: a second identical access, with ack 3 cycles after the first.
